// File: rtl/uart_top_pkg.sv
// uart_top_pkg: framing constants, status codes and parser state encoding shared by the UART bridge
package uart_top_pkg;
  localparam logic [7:0] START_BYTE = 8'h5A;
  localparam logic [7:0] PT_APP = 8'h01;
  localparam logic [7:0] PT_ETH = 8'h10;
  localparam logic [7:0] PT_RESP = 8'h80;
  localparam logic [15:0] CMD_CONNECT = 16'h0001;
  localparam logic [15:0] CMD_CLOSE = 16'h0002;
  localparam logic [7:0] ST_OK = 8'h00;
  localparam logic [7:0] ST_NOT_CONN = 8'h01;
  localparam logic [7:0] ST_MALFORMED = 8'h02;
  localparam logic [7:0] ST_UNSUPPORTED = 8'h03;
  typedef enum logic [2:0] {
    IDLE = 3'd0, TYPE = 3'd1, LEN_HI = 3'd2, LEN_LO = 3'd3,
    PAYLOAD = 3'd4, CRC_HI = 3'd5, CRC_LO = 3'd6
  } parser_state_e;
endpackage

// File: rtl/uart_core.sv
// uart_core: 8N1 receiver with 2-flop sync and mid-bit sampling, plus 8N1 transmitter
module uart_core #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  logic [1:0] sync;
  logic rx_prev, rx_busy;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_idx, tx_idx;
  logic [7:0] rx_sh;
  logic [8:0] tx_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      rx_prev <= sync[1];
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt <= CW'(BAUD_DIV / 2 - 1);
          rx_idx <= '0;
        end
      end else if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
      else begin
        rx_cnt <= CW'(BAUD_DIV - 1);
        rx_idx <= rx_idx + 1'b1;
        // idx 0 re-checks the start bit, 9 is the stop bit
        if (rx_idx == 4'd0) rx_busy <= !sync[1];
        else if (rx_idx == 4'd9) begin
          rx_busy <= 1'b0;
          rx_data <= rx_sh;
          rx_valid <= sync[1];
        end else rx_sh <= {sync[1], rx_sh[7:1]};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx <= 1'b0;
        tx_sh <= {1'b1, tx_data};
        tx_cnt <= CW'(BAUD_DIV - 1);
        tx_idx <= '0;
      end
    end else if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
    else if (tx_idx == 4'd9) tx_busy <= 1'b0;
    else begin
      tx <= tx_sh[0];
      tx_sh <= {1'b1, tx_sh[8:1]};
      tx_idx <= tx_idx + 1'b1;
      tx_cnt <= CW'(BAUD_DIV - 1);
    end
endmodule

// File: rtl/uart_top.sv
// uart_top: packet parser, connection/ETH filtering and 8-byte status responses over a UART
module uart_top
  import uart_top_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] debug_status,
  output logic       connection_active
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int GAP_MAX = 16 * BAUD_DIV * 10;
  localparam int GW = $clog2(GAP_MAX + 1);
  if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("uart_top: DATA_WIDTH must be 8..64 in steps of 8");
  end
  logic [7:0] rx_data, tx_data, ptype, status, cur_type, cur_status, pend_type, pend_status;
  logic rx_valid, tx_busy, tx_start, timeout, done, app_ok, eth_good, eth_ok;
  logic sending, pend_valid;
  logic [2:0] byte_idx;
  logic [15:0] len, idx, cmd;
  logic [GW-1:0] gap;
  logic [3:0] count;
  parser_state_e state, nxt;
  uart_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx), .tx(uart_tx),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );
  assign timeout = state != IDLE && gap == GW'(GAP_MAX);
  assign done = rx_valid && !timeout && state == CRC_LO;
  assign app_ok = len >= 16'd2 && (cmd == CMD_CONNECT || cmd == CMD_CLOSE);
  assign eth_good = eth_ok && len >= 16'd54;
  assign status = ptype == PT_APP ? (app_ok ? ST_OK : ST_UNSUPPORTED) :
                  ptype == PT_ETH ? (!eth_good ? ST_MALFORMED : !connection_active ? ST_NOT_CONN : ST_OK) :
                  ST_UNSUPPORTED;
  assign debug_status = {connection_active, state, count};
  always_comb begin
    nxt = state;
    if (timeout) nxt = IDLE;
    else if (rx_valid)
      case (state)
        IDLE:    nxt = rx_data == START_BYTE ? TYPE : IDLE;
        TYPE:    nxt = LEN_HI;
        LEN_HI:  nxt = LEN_LO;
        LEN_LO:  nxt = {len[15:8], rx_data} == 16'd0 ? CRC_HI : PAYLOAD;
        PAYLOAD: nxt = idx == len - 1'b1 ? CRC_HI : PAYLOAD;
        CRC_HI:  nxt = CRC_LO;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gap <= '0;
      ptype <= '0;
      len <= '0;
      idx <= '0;
      cmd <= '0;
      eth_ok <= 1'b0;
      connection_active <= 1'b0;
      count <= '0;
    end else begin
      state <= nxt;
      gap <= (state == IDLE || rx_valid) ? '0 : gap + 1'b1;
      if (rx_valid && !timeout) begin
        if (state == TYPE) ptype <= rx_data;
        if (state == LEN_HI) len[15:8] <= rx_data;
        if (state == LEN_LO) begin
          len[7:0] <= rx_data;
          idx <= '0;
          cmd <= '0;
          eth_ok <= 1'b1;
        end
        // ethertype and IP protocol are checked as the bytes stream past
        if (state == PAYLOAD) begin
          idx <= idx + 1'b1;
          if (idx == 16'd0) cmd[15:8] <= rx_data;
          if (idx == 16'd1) cmd[7:0] <= rx_data;
          if ((idx == 16'd12 && rx_data != 8'h08) || (idx == 16'd13 && rx_data != 8'h00) ||
              (idx == 16'd23 && rx_data != 8'h06)) eth_ok <= 1'b0;
        end
      end
      if (done && ptype == PT_APP && app_ok) connection_active <= cmd == CMD_CONNECT;
      if (done && ptype == PT_ETH && eth_good && connection_active) count <= count + 1'b1;
    end
  assign tx_start = sending && !tx_busy;
  assign tx_data = byte_idx == 3'd0 ? START_BYTE : byte_idx == 3'd1 ? PT_RESP :
                   byte_idx == 3'd3 ? 8'h02 : byte_idx == 3'd4 ? cur_type :
                   byte_idx == 3'd5 ? cur_status : 8'h00;
  // one response in flight plus one pending slot; a third concurrent response is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sending <= 1'b0;
      byte_idx <= '0;
      cur_type <= '0;
      cur_status <= '0;
      pend_valid <= 1'b0;
      pend_type <= '0;
      pend_status <= '0;
    end else begin
      if (tx_start) byte_idx <= byte_idx + 1'b1;
      if (tx_start && byte_idx == 3'd7) sending <= 1'b0;
      if (!sending && pend_valid) begin
        sending <= 1'b1;
        cur_type <= pend_type;
        cur_status <= pend_status;
        pend_valid <= 1'b0;
      end
      if (done) begin
        if (!sending && !pend_valid) begin
          sending <= 1'b1;
          cur_type <= ptype;
          cur_status <= status;
        end else if (!pend_valid || !sending) begin
          pend_valid <= 1'b1;
          pend_type <= ptype;
          pend_status <= status;
        end
      end
    end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed packet sequence with immediate-assertion checks on responses and status
module tb_uart_top;
  localparam int BD = 8;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n, uart_rx, uart_tx, connection_active;
  logic [7:0] debug_status;
  logic [7:0] rx_q[$];
  int n_chk = 0, n_fail = 0;

  uart_top #(.DATA_WIDTH(64), .BAUD_RATE(100000), .CLK_FREQ(800000)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .debug_status(debug_status), .connection_active(connection_active)
  );

  always #5 clk = ~clk;

  initial forever begin
    logic [7:0] b;
    @(negedge uart_tx);
    repeat (BD / 2) @(negedge clk);
    if (uart_tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BD) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_pkt(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic get_resp(input string tag, input logic [63:0] exp);
    logic [63:0] got = 'x;
    int t = 0;
    while (rx_q.size() < 8 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (rx_q.size() >= 8)
      for (int i = 0; i < 8; i++) got = {got[55:0], rx_q.pop_front()};
    chk(tag, got, exp);
  endtask

  function automatic bq_t eth_pkt(input int n, input logic [15:0] et);
    bq_t q;
    logic [7:0] b;
    q = {8'h5A, 8'h10, 8'(n >> 8), 8'(n)};
    for (int i = 0; i < n; i++) begin
      b = (i < 54) ? 8'(i) : 8'(8'h41 + i - 54);
      if (i == 12) b = et[15:8];
      if (i == 13) b = et[7:0];
      if (i == 23) b = 8'h06;
      q.push_back(b);
    end
    q.push_back(8'hC3);
    q.push_back(8'h3C);
    return q;
  endfunction

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(uart_tx), 64'h1);
    chk("reset_conn", 64'(connection_active), 64'h0);
    chk("reset_dbg", 64'(debug_status), 64'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_byte(8'h11);
    send_byte(8'h22);
    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00});
    get_resp("connect_resp", 64'h5A80_0002_0100_0000);
    chk("connect_conn", 64'(connection_active), 64'h1);
    chk("connect_dbg", 64'(debug_status), 64'h80);

    send_pkt(eth_pkt(74, 16'h0800));
    get_resp("eth74_resp", 64'h5A80_0002_1000_0000);
    chk("eth74_dbg", 64'(debug_status), 64'h81);

    send_pkt(eth_pkt(94, 16'h0800));
    get_resp("eth94_resp", 64'h5A80_0002_1000_0000);
    chk("eth94_dbg", 64'(debug_status), 64'h82);

    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00});
    get_resp("close_resp", 64'h5A80_0002_0100_0000);
    chk("close_conn", 64'(connection_active), 64'h0);

    send_pkt(eth_pkt(74, 16'h0800));
    get_resp("eth_closed_resp", 64'h5A80_0002_1001_0000);
    chk("eth_closed_dbg", 64'(debug_status), 64'h02);

    send_pkt(eth_pkt(74, 16'h86DD));
    get_resp("eth_v6_resp", 64'h5A80_0002_1002_0000);

    send_pkt(eth_pkt(40, 16'h0800));
    get_resp("eth_short_resp", 64'h5A80_0002_1002_0000);

    send_pkt({8'h5A, 8'h01, 8'h00});
    chk("gap_mid_state", 64'(debug_status[6:4]), 64'h3);
    repeat (1400) @(negedge clk);
    chk("gap_abort_state", 64'(debug_status[6:4]), 64'h0);
    chk("gap_no_resp", 64'(rx_q.size()), 64'h0);

    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00});
    get_resp("close_closed_resp", 64'h5A80_0002_0100_0000);

    send_pkt({8'h5A, 8'h22, 8'h00, 8'h00, 8'hC1, 8'hC2});
    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00});
    get_resp("unknown_len0_resp", 64'h5A80_0002_2203_0000);
    get_resp("bad_cmd_resp", 64'h5A80_0002_0103_0000);

    send_pkt({8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'hCC, 8'hCC});
    get_resp("app_len1_resp", 64'h5A80_0002_0103_0000);

    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00});
    get_resp("reconnect_resp", 64'h5A80_0002_0100_0000);
    chk("reconnect_dbg", 64'(debug_status), 64'h82);

    send_pkt({8'h5A, 8'h10, 8'h00, 8'h4A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 64'(uart_tx), 64'h1);
    chk("midrst_conn", 64'(connection_active), 64'h0);
    chk("midrst_dbg", 64'(debug_status), 64'h00);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_pkt({8'h5A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00});
    get_resp("post_rst_resp", 64'h5A80_0002_0100_0000);
    chk("post_rst_dbg", 64'(debug_status), 64'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
